// File: rtl/benes_route_sequencer.sv
// rtl/benes_route_sequencer.sv - config table, per-stage control skew and output FIFO for benes_xbar
// Requests issue at up to one per cycle; each xbar stage sees its control slice exactly when the data reaches it.

module benes_route_sequencer #(
    parameter int SIZE       = 32,
    parameter int DWIDTH     = 16,
    parameter int NUM_CFG    = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int TAGWIDTH  = $clog2(SIZE),
    localparam int STAGES    = 2 * TAGWIDTH - 1,
    localparam int CW        = STAGES * (SIZE / 2)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CFG)-1:0] cfg_waddr,
    input  logic [CW-1:0]              cfg_wdata,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(NUM_CFG)-1:0] in_cfg,
    input  logic [SIZE*DWIDTH-1:0]     in_data,
    output logic [SIZE*DWIDTH-1:0]     xb_in,
    output logic [CW-1:0]              xb_ctrl,
    input  logic [SIZE*DWIDTH-1:0]     xb_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIZE*DWIDTH-1:0]     out_data,
    output logic                       busy
);

    localparam int HALF = SIZE / 2;
    localparam int DW   = SIZE * DWIDTH;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = $clog2(FIFO_DEPTH + 1);

    typedef logic [NW-1:0] cnt_t;
    typedef logic [NW:0]   sum_t;
    typedef logic [PW-1:0] ptr_t;

    // Staircase layout: step d holds slices d..STAGES-1 of the request issued d cycles ago.
    function automatic int stair_off(input int d);
        return HALF * ((d - 1) * STAGES - ((d - 1) * d) / 2);
    endfunction

    localparam int TRI = stair_off(STAGES);

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [CW-1:0]       cfg_table [NUM_CFG];
    logic [CW-1:0]       cfg_rd;
    logic                fire;
    logic [STAGES-1:1]   vld_q;
    logic [TRI-1:0]      tri_q;
    logic [TRI-1:0]      tri_d;
    logic [DW-1:0]       mem [FIFO_DEPTH];
    ptr_t                wr_ptr_q;
    ptr_t                rd_ptr_q;
    cnt_t                count_q;
    cnt_t                count_d;
    cnt_t                inflight_q;
    cnt_t                inflight_d;
    logic                push;
    logic                pop;

    // The read happens before this cycle's write lands, so a same-cycle issue sees old contents.
    assign cfg_rd = cfg_table[in_cfg];
    assign fire   = in_valid & in_ready;
    assign xb_in  = in_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_table[i] <= '0;
            end
        end else if (cfg_we) begin
            cfg_table[cfg_waddr] <= cfg_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[STAGES-2:1], fire};
        end
    end

    always_comb begin
        tri_d = '0;
        for (int d = 1; d < STAGES; d++) begin
            for (int k = d; k < STAGES; k++) begin
                if (d == 1) begin
                    tri_d[stair_off(1) + (k - 1) * HALF +: HALF] = cfg_rd[k * HALF +: HALF];
                end else begin
                    tri_d[stair_off(d) + (k - d) * HALF +: HALF] =
                        tri_q[stair_off(d - 1) + (k - d + 1) * HALF +: HALF];
                end
            end
        end
    end

    // Control payload needs no reset: every use is gated by its valid bit.
    always_ff @(posedge CLK) begin
        tri_q <= tri_d;
    end

    always_comb begin
        xb_ctrl = '0;
        if (fire) begin
            xb_ctrl[HALF-1:0] = cfg_rd[HALF-1:0];
        end
        for (int d = 1; d < STAGES; d++) begin
            if (vld_q[d]) begin
                xb_ctrl[d * HALF +: HALF] = tri_q[stair_off(d) +: HALF];
            end
        end
    end

    assign push      = vld_q[STAGES-1];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr_q];
    assign busy      = (|vld_q) | (count_q != '0);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= xb_out;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        inflight_d = inflight_q;
        case ({fire, push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Every accepted request reserves a FIFO entry, so a push can never find the FIFO full.
    assign in_ready = (sum_t'(count_q) + sum_t'(inflight_q)) < sum_t'(FIFO_DEPTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            assert (!(push && !pop && count_q == cnt_t'(FIFO_DEPTH)));
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_benes_route_sequencer.sv
// tb/tb_benes_route_sequencer.sv - scoreboard bench for benes_route_sequencer with a pipelined xbar model
// Directed skew/latency sequences, a table-driven request stream, backpressure, same-cycle write and reset.

module tb_benes_route_sequencer;

    localparam int SIZE       = 32;
    localparam int DWIDTH     = 16;
    localparam int NUM_CFG    = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int TAGWIDTH   = $clog2(SIZE);
    localparam int STAGES     = 2 * TAGWIDTH - 1;
    localparam int HALF       = SIZE / 2;
    localparam int CW         = STAGES * HALF;
    localparam int W          = SIZE * DWIDTH;
    localparam int CIW        = $clog2(NUM_CFG);
    localparam int NREC       = 24;

    typedef logic [W-1:0]  vec_w_t;
    typedef logic [CW-1:0] cfg_t;

    typedef struct {
        logic [CIW-1:0] cfg;
        vec_w_t         data;
        vec_w_t         exp;
    } rec_t;

    logic           CLK;
    logic           RST;
    logic           cfg_we;
    logic [CIW-1:0] cfg_waddr;
    cfg_t           cfg_wdata;
    logic           in_valid;
    logic           in_ready;
    logic [CIW-1:0] in_cfg;
    vec_w_t         in_data;
    vec_w_t         xb_in;
    cfg_t           xb_ctrl;
    vec_w_t         xb_out;
    logic           out_valid;
    logic           out_ready;
    vec_w_t         out_data;
    logic           busy;

    benes_route_sequencer #(
        .SIZE(SIZE), .DWIDTH(DWIDTH), .NUM_CFG(NUM_CFG), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_cfg(in_cfg), .in_data(in_data),
        .xb_in(xb_in), .xb_ctrl(xb_ctrl), .xb_out(xb_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Butterfly / inverse-butterfly Benes: stage s pairs elements differing in one index bit.
    function automatic vec_w_t stage_fn(input int s, input vec_w_t d, input logic [HALF-1:0] c);
        vec_w_t r;
        int b, lo, hi;
        r = d;
        b = (s < TAGWIDTH) ? s : 2 * TAGWIDTH - 2 - s;
        for (int k = 0; k < HALF; k++) begin
            lo = ((k >> b) << (b + 1)) | (k & ((1 << b) - 1));
            hi = lo | (1 << b);
            if (c[k]) begin
                r[lo*DWIDTH +: DWIDTH] = d[hi*DWIDTH +: DWIDTH];
                r[hi*DWIDTH +: DWIDTH] = d[lo*DWIDTH +: DWIDTH];
            end
        end
        return r;
    endfunction

    function automatic vec_w_t ref_perm(input vec_w_t d, input cfg_t c);
        vec_w_t r;
        r = d;
        for (int s = 0; s < STAGES; s++) begin
            r = stage_fn(s, r, c[s*HALF +: HALF]);
        end
        return r;
    endfunction

    function automatic vec_w_t swap_pairs(input vec_w_t d);
        vec_w_t r;
        for (int k = 0; k < HALF; k++) begin
            r[(2*k)*DWIDTH +: DWIDTH]   = d[(2*k+1)*DWIDTH +: DWIDTH];
            r[(2*k+1)*DWIDTH +: DWIDTH] = d[(2*k)*DWIDTH +: DWIDTH];
        end
        return r;
    endfunction

    function automatic vec_w_t ident();
        vec_w_t r;
        for (int i = 0; i < SIZE; i++) r[i*DWIDTH +: DWIDTH] = DWIDTH'(i);
        return r;
    endfunction

    function automatic vec_w_t rand_vec();
        vec_w_t r;
        for (int i = 0; i < SIZE; i++) r[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
        return r;
    endfunction

    // Pipelined xbar model with a register between consecutive stages.
    vec_w_t so [STAGES];
    vec_w_t pr [1:STAGES-1];

    always_comb begin
        so[0] = stage_fn(0, xb_in, xb_ctrl[HALF-1:0]);
        for (int s = 1; s < STAGES; s++) begin
            so[s] = stage_fn(s, pr[s], xb_ctrl[s*HALF +: HALF]);
        end
    end

    always @(posedge CLK) begin
        for (int s = 1; s < STAGES; s++) pr[s] <= so[s-1];
    end

    assign xb_out = so[STAGES-1];

    vec_w_t sb [$];
    vec_w_t drv_exp;
    int     n_vec = 0;
    int     n_err = 0;
    cfg_t   cfg_val [NUM_CFG];
    cfg_t   shadow  [NUM_CFG];
    rec_t   tbl     [NREC];

    task automatic check(input string name, input vec_w_t act, input vec_w_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected no output", out_data);
                end else begin
                    check("out_data", out_data, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(drv_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_cfg(input int idx, input cfg_t val);
        cfg_we    = 1'b1;
        cfg_waddr = CIW'(idx);
        cfg_wdata = val;
        tick();
        cfg_we = 1'b0;
        shadow[idx] = val;
    endtask

    // Single request into an idle pipe: checks every skewed control slice and the exact latency.
    task automatic directed(input int cfg, input vec_w_t data, input vec_w_t exp, input string tag);
        cfg_t ectl;
        in_valid = 1'b1;
        in_cfg   = CIW'(cfg);
        in_data  = data;
        drv_exp  = exp;
        #1;
        for (int k = 0; k <= STAGES; k++) begin
            if (k > 0) begin
                tick();
                in_valid = 1'b0;
                #1;
            end
            ectl = '0;
            if (k < STAGES) ectl[k*HALF +: HALF] = shadow[cfg][k*HALF +: HALF];
            check({tag, "_ctrl"}, xb_ctrl, ectl);
            if (k == STAGES - 1) check({tag, "_early_valid"}, out_valid, 1'b0);
            if (k == STAGES) begin
                check({tag, "_valid"}, out_valid, 1'b1);
                check({tag, "_data"}, out_data, exp);
            end
        end
        tick();
    endtask

    initial begin
        vec_w_t d1, d2;
        int     accepted;

        for (int i = 0; i < NUM_CFG; i++) begin
            cfg_val[i] = '0;
            shadow[i]  = '0;
        end
        cfg_val[1][HALF-1:0] = '1;
        cfg_val[2][(STAGES-1)*HALF +: HALF] = '1;
        for (int b = 0; b < CW; b++) cfg_val[3][b] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NREC; i++) begin
            tbl[i].cfg  = (i < 20) ? CIW'(i % 2) : CIW'(3);
            tbl[i].data = rand_vec();
            tbl[i].exp  = ref_perm(tbl[i].data, cfg_val[tbl[i].cfg]);
        end

        RST = 1'b1; cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_cfg = '0; in_data = '0; out_ready = 1'b0; drv_exp = '0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_xb_ctrl", xb_ctrl, '0);
        tick();

        out_ready = 1'b1;
        directed(0, ident(), ident(), "cfg0");
        write_cfg(1, cfg_val[1]);
        directed(1, ident(), swap_pairs(ident()), "cfg1");
        write_cfg(3, cfg_val[3]);
        d1 = rand_vec();
        directed(3, d1, ref_perm(d1, cfg_val[3]), "cfg3");

        // Back-to-back stream: one output per cycle from cycle STAGES onwards, in order.
        for (int k = 0; k < NREC + STAGES + 1; k++) begin
            if (k < NREC) begin
                in_valid = 1'b1;
                in_cfg   = tbl[k].cfg;
                in_data  = tbl[k].data;
                drv_exp  = tbl[k].exp;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < NREC) check("stream_ready", in_ready, 1'b1);
            check("stream_valid", out_valid, 1'((k >= STAGES) && (k < NREC + STAGES)));
            tick();
        end

        // Backpressure: credit admits exactly FIFO_DEPTH requests.
        out_ready = 1'b0;
        accepted  = 0;
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'b1;
            in_cfg   = CIW'(3);
            in_data  = rand_vec();
            drv_exp  = ref_perm(in_data, shadow[3]);
            #1;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepted", vec_w_t'(accepted), vec_w_t'(FIFO_DEPTH));
        check("bp_ready_full", in_ready, 1'b0);
        check("bp_valid_full", out_valid, 1'b1);
        tick();
        out_ready = 1'b1;
        #1;
        check("bp_ready_pop_cycle", in_ready, 1'b0);
        tick();
        check("bp_ready_after_pop", in_ready, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("bp_drained", vec_w_t'(sb.size()), '0);
        check("bp_empty_valid", out_valid, 1'b0);

        // Same-cycle write and issue of cfg 2 uses the old all-zero routing.
        d1 = rand_vec();
        d2 = rand_vec();
        cfg_we = 1'b1; cfg_waddr = CIW'(2); cfg_wdata = cfg_val[2];
        in_valid = 1'b1; in_cfg = CIW'(2); in_data = d1; drv_exp = d1;
        #1;
        check("wr_issue_ctrl", xb_ctrl, '0);
        tick();
        cfg_we = 1'b0;
        shadow[2] = cfg_val[2];
        in_valid = 1'b1; in_cfg = CIW'(2); in_data = d2; drv_exp = swap_pairs(d2);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("wr_drained", vec_w_t'(sb.size()), '0);

        // Reset with 3 results in the FIFO and 5 requests in the skew pipe.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                in_valid = 1'b0;
                repeat (10) tick();
                check("pre_rst_fifo_valid", out_valid, 1'b1);
            end
            in_valid = 1'b1; in_cfg = CIW'(0); in_data = rand_vec(); drv_exp = in_data;
            tick();
        end
        in_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("pre_rst_busy", busy, 1'b1);
        sb.delete();
        tick();
        RST = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_xb_ctrl", xb_ctrl, '0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_rst_quiet", out_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/benes_route_sequencer.md
Name: benes_route_sequencer

Overview:
- Upstream control and sequencing stage for benes_xbar.
- Holds a table of precomputed Benes routing configurations and accepts permutation requests (data vector plus config index) over a valid/ready handshake.
- Skews each stage's control slice in time so it lines up with the xbar's internal inter-stage registers, tracks request validity through the xbar pipeline, and captures xbar outputs into a FIFO.
- The output FIFO presents results on a valid/ready handshake, with credit-based backpressure to the input side.

Parameters:
- SIZE, 32, xbar port count (power of two, >=4).
- DWIDTH, 16, element width.
- NUM_CFG, 8, routing configurations held in the table.
- FIFO_DEPTH, 16, output FIFO entries; must be >= STAGES.
- TAGWIDTH (local), $clog2(SIZE).
- STAGES (local), 2*TAGWIDTH-1.
- CW (local), STAGES*(SIZE/2), control vector width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- cfg_we  in  1  config table write strobe.
- cfg_waddr  in  $clog2(NUM_CFG)  write index.
- cfg_wdata  in  CW  control vector; stage s uses bits [s*SIZE/2 +: SIZE/2].
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_cfg  in  $clog2(NUM_CFG)  config index for the request.
- in_data  in  SIZE*DWIDTH  element i at [i*DWIDTH +: DWIDTH].
- xb_in  out  SIZE*DWIDTH  to xbar data inputs.
- xb_ctrl  out  CW  to xbar control_bit.
- xb_out  in  SIZE*DWIDTH  from xbar outputs.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pop.
- out_data  out  SIZE*DWIDTH  FIFO head.
- busy  out  1  any request in flight or FIFO non-empty.

Behaviour:
- Config table: NUM_CFG x CW registers, all cleared to 0 on RST (0 = straight-through routing).
- Write takes effect the cycle after cfg_we.
- An issue in the same cycle as a write to the same index uses the old contents.
- Issue (fire = in_valid & in_ready):
  - xb_in = in_data every cycle (combinational pass-through).
  - Stage-0 slice of xb_ctrl = table[in_cfg] when fire, else 0.
- Skew pipeline: for s = 1..STAGES-1, register slot s holds {valid, ctrl slice s} of the request issued s cycles earlier.
  - xb_ctrl slice s = slot s ctrl when slot s is valid, else 0.
  - Slots shift every cycle; there is no stall, because the xbar cannot stall.
  - Each slot stores only its own slice: slot s is loaded from table[in_cfg] slice s at issue and moves with the request's stage. Equivalent staircase storage is acceptable.
- Latency: request issued in cycle t appears on xb_out in cycle t+STAGES-1 (8 for SIZE=32).
  - It is written into the FIFO at the end of that cycle.
  - out_valid rises in cycle t+STAGES at the earliest.
  - Back-to-back issue is allowed (throughput 1/cycle).
- FIFO: first-word-fall-through, depth FIFO_DEPTH, with pointer wrap-around.
  - Push occurs when the last skew slot is valid.
  - Pop occurs when out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged and is legal even when the FIFO is full.
  - When the FIFO is empty, out_data is don't-care and out_valid = 0.
- Credit:
  - inflight = number of valid skew slots plus the current-cycle issue.
  - in_ready = (fifo_count_q + inflight_q) < FIFO_DEPTH, computed from registered counts only; a same-cycle pop is not credited until the next cycle.
  - This guarantees a push never targets a full FIFO.
  - An overflow attempt is an assertion error.
- in_ready is independent of in_valid.
- A request is never dropped once accepted.
- Reset:
  - Outputs after RST: in_ready=1, out_valid=0, busy=0, xb_ctrl=0.
  - Counts and pointers are 0; all skew slots are invalid.
  - Reset mid-operation discards in-flight requests and FIFO contents; no push occurs in the cycle after reset.
- busy = any valid skew slot | fifo_count != 0.

Test Plan:
- Reset, cfg 0 untouched; issue in_data[i]=i at t=0 with out_ready=1 -> out_valid at t=9 (SIZE=32), out_data[i]=i, xb_ctrl=0 throughout.
- Write cfg 1 with stage-0 slice all ones, remaining slices 0; issue cfg 1, in_data[i]=i -> out_data[2k]=2k+1, out_data[2k+1]=2k. xb_ctrl stage-0 bits are set only in the issue cycle; stage-s bits are set only at t+s.
- Alternate cfg 0 and cfg 1 every cycle for 20 requests -> outputs emerge in order, each matching its own config, one per cycle starting at t=9.
- out_ready=0, continuous in_valid, FIFO_DEPTH=16 -> exactly 16 accepted, then in_ready=0. Raise out_ready -> 16 pops in order; in_ready returns 1 the cycle after the first pop.
- In the same cycle, write cfg 2 with a swap vector and issue cfg 2 -> output uses the old (zero) config. The next issue of cfg 2 uses the new config.
- Assert RST with 5 requests in flight and 3 in the FIFO -> next cycle out_valid=0, busy=0, in_ready=1; no stale output appears in the following 10 cycles.
